// File: rtl/envelope_detector.sv
// Magnitude/envelope detector for a complex (Re/Im) stream.
// Alpha-max-beta-min magnitude, block-average envelope, and hysteretic detect FSM.
module envelope_detector #(
  parameter int total_bits = 12,
  parameter int avg_log2   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [total_bits-1:0] Re,
  input  logic signed [total_bits-1:0] Im,
  input  logic        [total_bits:0]   th_on,
  input  logic        [total_bits:0]   th_off,
  output logic        [total_bits:0]   mag,
  output logic                         mag_valid,
  output logic        [total_bits:0]   env,
  output logic                         env_valid,
  output logic                         detect
);
  localparam int W  = total_bits;
  localparam int AW = total_bits + 1 + avg_log2;

  typedef enum logic [1:0] {IDLE, PENDING, ACTIVE} state_t;

  logic signed [W-1:0] iq [2];
  logic                v1_reg;
  logic                v2_reg;
  logic [W-1:0]        max_reg;
  logic [W-1:0]        min_reg;
  logic [W:0]          mag_reg;
  logic                mag_valid_reg;
  logic [AW-1:0]       acc_reg;
  logic [AW-1:0]       sum_next;
  logic [avg_log2-1:0] cnt_reg;
  logic [W:0]          env_reg;
  logic                env_valid_reg;
  state_t              state_reg;
  logic                detect_reg;

  assign iq[0] = Re;
  assign iq[1] = Im;

  // Stage 1: absolute values; the most negative input wraps to 2^(W-1) as unsigned.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_abs
      logic [W-1:0] abs_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          abs_reg <= '0;
        end else begin
          abs_reg <= iq[gi][W-1] ? $unsigned(-iq[gi]) : $unsigned(iq[gi]);
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      v1_reg <= 1'b0;
    end else begin
      v1_reg <= in_valid;
    end
  end

  // Stage 2: sort the two magnitudes.
  always_ff @(posedge clock) begin
    if (reset) begin
      v2_reg  <= 1'b0;
      max_reg <= '0;
      min_reg <= '0;
    end else begin
      v2_reg <= v1_reg;
      if (g_abs[0].abs_reg >= g_abs[1].abs_reg) begin
        max_reg <= g_abs[0].abs_reg;
        min_reg <= g_abs[1].abs_reg;
      end else begin
        max_reg <= g_abs[1].abs_reg;
        min_reg <= g_abs[0].abs_reg;
      end
    end
  end

  // Stage 3: max + 3/8*min; worst case 1.375*2^(W-1) fits in W+1 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      mag_reg       <= '0;
      mag_valid_reg <= 1'b0;
    end else begin
      mag_valid_reg <= v2_reg;
      if (v2_reg) begin
        mag_reg <= (W+1)'(max_reg) + (W+1)'(min_reg >> 2) + (W+1)'(min_reg >> 3);
      end
    end
  end

  assign sum_next = acc_reg + AW'(mag_reg);

  // Window closes on the last sample: publish and restart on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      env_reg       <= '0;
      env_valid_reg <= 1'b0;
    end else begin
      env_valid_reg <= 1'b0;
      if (mag_valid_reg) begin
        if (cnt_reg == '1) begin
          env_reg       <= sum_next[AW-1:avg_log2];
          env_valid_reg <= 1'b1;
          acc_reg       <= '0;
          cnt_reg       <= '0;
        end else begin
          acc_reg <= sum_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  // Detect needs two consecutive windows above th_on to assert.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      detect_reg <= 1'b0;
    end else if (env_valid_reg) begin
      case (state_reg)
        IDLE: begin
          if (env_reg >= th_on) state_reg <= PENDING;
        end
        PENDING: begin
          if (env_reg >= th_on) begin
            state_reg  <= ACTIVE;
            detect_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        ACTIVE: begin
          if (env_reg < th_off) begin
            state_reg  <= IDLE;
            detect_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= IDLE;
          detect_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mag       = mag_reg;
  assign mag_valid = mag_valid_reg;
  assign env       = env_reg;
  assign env_valid = env_valid_reg;
  assign detect    = detect_reg;

endmodule
